// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code sequencing controller:
// FSM state encoding, command opcodes and the binary-to-Gray helper.
package gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FREE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_RUN   = 2'b01,
        OP_FREE  = 2'b10,
        OP_STOP  = 2'b11
    } op_t;

    localparam int unsigned GRAY_MAX_W = 32;

    // Reflected binary Gray code; callers zero-extend and truncate to their width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step.sv
// Count register with clear/increment controls and a registered wrap pulse.
// Clear has priority over increment; wrap fires only when an increment
// rolls all-ones over to zero.
module gray_step #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    // Count and wrap update; wrap is a one-cycle pulse aligned with count==0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (inc) begin
            count <= count + 1'b1;
            wrap  <= &count;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven Gray-code sequencer: bounded RUN, free-running FREE,
// CLEAR and STOP, with done/wrap/err status pulses.
module gray_seq_ctrl
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    // Set when DONE was entered from a zero-length RUN: the done pulse is
    // then issued one edge later so it lands in the cycle after edge k+1.
    logic               zlen;
    logic               accept;
    logic               clr;
    logic               inc;

    assign cmd_ready = (state == ST_IDLE) || (state == ST_FREE);
    assign busy      = (state == ST_RUN)  || (state == ST_FREE);
    assign accept    = cmd_valid && cmd_ready;
    assign out       = WIDTH'(bin2gray(GRAY_MAX_W'(count)));

    // Counter controls derived from current state and the accepted command.
    always_comb begin
        clr = 1'b0;
        inc = 1'b0;
        case (state)
            ST_IDLE: clr = accept && (cmd_op == OP_CLEAR);
            ST_RUN:  inc = 1'b1;
            ST_FREE: inc = !(accept && (cmd_op == OP_STOP));
            default: ;
        endcase
    end

    gray_step #(.WIDTH(WIDTH)) u_step (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (inc),
        .count (count),
        .wrap  (wrap)
    );

    // Sequencing FSM with registered done/err pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            zlen      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_RUN: begin
                                if (cmd_len == '0) begin
                                    state <= ST_DONE;
                                    zlen  <= 1'b1;
                                end else begin
                                    state     <= ST_RUN;
                                    remaining <= cmd_len;
                                end
                            end
                            OP_FREE: state <= ST_FREE;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_FREE: begin
                    if (accept) begin
                        if (cmd_op == OP_STOP) state <= ST_IDLE;
                        else                   err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (zlen) begin
                        zlen <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl at WIDTH=4 with hand-computed expectations.
module tb_gray_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;
    localparam logic [1:0] C_CLEAR = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_FREE  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             err;

    int checks = 0;
    int errors = 0;

    gray_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .count     (count),
        .out       (out),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one edge; samples are taken 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge, then scramble the fields.
    task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = C_CLEAR;
        cmd_len   = 8'hA5;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 4'd0 || out !== 4'd0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
            done !== 1'b0 || wrap !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d out=%0d busy=%b ready=%b done=%b wrap=%b err=%b, required 0 0 0 1 0 0 0",
                     count, out, busy, cmd_ready, done, wrap, err);
        end
    endtask

    task automatic test_run5();
        logic [3:0] exp_out [6];
        int nbusy;
        int ndone;
        exp_out = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7};
        issue(C_RUN, 8'd5);
        nbusy = int'(busy);
        ndone = int'(done);
        checks++;
        if (out !== exp_out[0]) begin
            errors++;
            $display("FAIL run5_out0: out=%0d, required %0d", out, exp_out[0]);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            nbusy += int'(busy);
            ndone += int'(done);
            checks++;
            if (out !== exp_out[i]) begin
                errors++;
                $display("FAIL run5_out%0d: out=%0d, required %0d", i, out, exp_out[i]);
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL run5_done_edge: done=%b, required 1", done);
        end
        tick();
        ndone += int'(done);
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL run5_count: count=%0d, required 5", count);
        end
        checks++;
        if (nbusy != 5) begin
            errors++;
            $display("FAIL run5_busy_cycles: got %0d, required 5", nbusy);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL run5_done_cycles: got %0d, required 1", ndone);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_cnt [3];
        logic [3:0] exp_gry [3];
        logic       exp_wrp [3];
        int nwrap;
        exp_cnt = '{4'd15, 4'd0, 4'd1};
        exp_gry = '{4'd8, 4'd0, 4'd1};
        exp_wrp = '{1'b0, 1'b1, 1'b0};
        // 5 + 9 = 14
        issue(C_RUN, 8'd9);
        repeat (10) tick();
        checks++;
        if (count !== 4'd14 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_setup: count=%0d ready=%b, required 14 1", count, cmd_ready);
        end
        issue(C_RUN, 8'd3);
        nwrap = int'(wrap);
        for (int i = 0; i < 3; i++) begin
            tick();
            nwrap += int'(wrap);
            checks++;
            if (count !== exp_cnt[i] || out !== exp_gry[i] || wrap !== exp_wrp[i]) begin
                errors++;
                $display("FAIL wrap_step%0d: count=%0d out=%0d wrap=%b, required %0d %0d %b",
                         i, count, out, wrap, exp_cnt[i], exp_gry[i], exp_wrp[i]);
            end
        end
        tick();
        nwrap += int'(wrap);
        checks++;
        if (nwrap != 1) begin
            errors++;
            $display("FAIL wrap_pulses: got %0d, required 1", nwrap);
        end
    endtask

    task automatic test_free_stop();
        int ndone;
        do_reset();
        issue(C_FREE, 8'd0);
        ndone = int'(done);
        repeat (20) begin
            tick();
            ndone += int'(done);
        end
        cmd_valid = 1'b1;
        cmd_op    = C_STOP;
        tick();
        cmd_valid = 1'b0;
        ndone += int'(done);
        checks++;
        if (count !== 4'd4 || out !== 4'd6 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL free_stop: count=%0d out=%0d busy=%b ready=%b, required 4 6 0 1",
                     count, out, busy, cmd_ready);
        end
        tick();
        ndone += int'(done);
        checks++;
        if (count !== 4'd4 || ndone != 0) begin
            errors++;
            $display("FAIL free_stop_hold: count=%0d done_cycles=%0d, required 4 0", count, ndone);
        end
    endtask

    task automatic test_run_zero();
        issue(C_RUN, 8'd5);
        repeat (6) tick();
        checks++;
        if (count !== 4'd9) begin
            errors++;
            $display("FAIL zero_setup: count=%0d, required 9", count);
        end
        issue(C_RUN, 8'd0);
        checks++;
        if (done !== 1'b0 || count !== 4'd9 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_accept: done=%b count=%0d ready=%b, required 0 9 0", done, count, cmd_ready);
        end
        tick();
        checks++;
        if (done !== 1'b1 || count !== 4'd9) begin
            errors++;
            $display("FAIL zero_done: done=%b count=%0d, required 1 9", done, count);
        end
        tick();
        checks++;
        if (done !== 1'b0 || count !== 4'd9 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_after: done=%b count=%0d ready=%b, required 0 9 1", done, count, cmd_ready);
        end
    endtask

    task automatic test_free_err();
        int nerr;
        issue(C_FREE, 8'd0);
        nerr = int'(err);
        tick();
        nerr += int'(err);
        cmd_valid = 1'b1;
        cmd_op    = C_RUN;
        cmd_len   = 8'd7;
        tick();
        cmd_valid = 1'b0;
        nerr += int'(err);
        checks++;
        if (count !== 4'd11 || err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL free_err_pulse: count=%0d err=%b busy=%b, required 11 1 1", count, err, busy);
        end
        tick();
        nerr += int'(err);
        checks++;
        if (count !== 4'd12 || err !== 1'b0 || nerr != 1) begin
            errors++;
            $display("FAIL free_err_cont: count=%0d err=%b err_cycles=%0d, required 12 0 1", count, err, nerr);
        end
        issue(C_STOP, 8'd0);
        checks++;
        if (count !== 4'd12 || busy !== 1'b0) begin
            errors++;
            $display("FAIL free_err_stop: count=%0d busy=%b, required 12 0", count, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        issue(C_RUN, 8'd10);
        ndone = int'(done);
        repeat (2) begin
            tick();
            ndone += int'(done);
        end
        checks++;
        if (count !== 4'd14) begin
            errors++;
            $display("FAIL midrst_pre: count=%0d, required 14", count);
        end
        do_reset();
        ndone += int'(done);
        checks++;
        if (count !== 4'd0 || out !== 4'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst: count=%0d out=%0d busy=%b ready=%b, required 0 0 0 1",
                     count, out, busy, cmd_ready);
        end
        repeat (12) begin
            tick();
            ndone += int'(done);
        end
        checks++;
        if (count !== 4'd0 || ndone != 0) begin
            errors++;
            $display("FAIL midrst_after: count=%0d done_cycles=%0d, required 0 0", count, ndone);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = C_CLEAR;
        cmd_len   = '0;
        test_reset();
        test_run5();
        test_wrap();
        test_free_stop();
        test_run_zero();
        test_free_err();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 Parameter WIDTH, 4, counter width in bits.
REQ-002 Parameter LEN_W, 8, width of the step-count field.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port cmd_valid  input  1  command present.
REQ-006 Port cmd_ready  output  1  controller accepts a command this cycle.
REQ-007 Port cmd_op  input  2  00 CLEAR, 01 RUN, 10 FREE, 11 STOP.
REQ-008 Port cmd_len  input  LEN_W  step count for RUN.
REQ-009 Port count  output  WIDTH  registered binary count.
REQ-010 Port out  output  WIDTH  Gray code of count.
REQ-011 Port busy  output  1  state is RUN or FREE.
REQ-012 Port done  output  1  one-cycle pulse when RUN completes.
REQ-013 Port wrap  output  1  one-cycle pulse when count wraps from all-ones to 0.
REQ-014 Port err  output  1  one-cycle pulse on an illegal command.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, RUN, FREE and DONE.
REQ-016 A command SHALL be accepted on a clock edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL be high in IDLE and FREE and low in RUN and DONE.
REQ-017 In IDLE: CLEAR sets count to 0, with the state staying IDLE. RUN with cmd_len=L>0 goes to RUN and loads remaining=L. RUN with L=0 goes to DONE with no increment. FREE goes to FREE. STOP is a no-op.
REQ-018 In RUN, count SHALL increment by 1 on each edge. After L increments (edges k+1..k+L, where k is the accept edge), the state SHALL be DONE.
REQ-019 In FREE, count SHALL increment on every edge until STOP is accepted. The STOP accept edge itself SHALL still not increment, and the state SHALL become IDLE.
REQ-020 In FREE, an accepted CLEAR, RUN or FREE SHALL be discarded, SHALL pulse err for one cycle, and SHALL leave the state and count unchanged.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE. For L>0, done is high in the cycle after edge k+L. For L=0, done is high in the cycle after edge k+1.
REQ-022 Increment SHALL be modulo 2^WIDTH. wrap SHALL be high in exactly the cycle in which count has just become 0 through an increment; CLEAR SHALL NOT assert wrap.
REQ-023 out SHALL equal count XOR (count >> 1), computed combinationally from the count register, with zero latency relative to count.
REQ-024 cmd_len and cmd_op SHALL be sampled only at the accept edge; later changes SHALL have no effect.
REQ-025 done, wrap and err SHALL be registered outputs.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set state=IDLE, count=0, remaining=0, and done=wrap=err=0, overriding any command or increment in the same cycle.
REQ-027 Reset asserted in the middle of RUN or FREE SHALL abort the operation with no done pulse. After that edge, out=0, busy=0 and cmd_ready=1.

Structure
REQ-028 A shared package gray_pkg SHALL hold the state enum, the cmd_op encodings and a bin2gray function.
REQ-029 One sub-module, gray_step, SHALL hold the count register with clear/increment controls and generate wrap; the FSM and handshake SHALL reside in gray_seq_ctrl.

Verification (WIDTH=4)
REQ-030 Reset, then RUN L=5: the bench SHALL require out sequence 0,1,3,2,6,7, final count=5, done high for exactly 1 cycle, and busy high for 5 cycles.
REQ-031 With count=14, RUN L=3: the bench SHALL require count 15,0,1, out 8,0,1, and wrap pulsed once, coincident with count=0.
REQ-032 FREE, then STOP issued 20 cycles after the FREE accept edge: the bench SHALL require final count=4, out=6, state IDLE, and no done pulse.
REQ-033 RUN L=0 with count=9: the bench SHALL require done high in the following cycle and count to stay 9.
REQ-034 RUN issued during FREE: the bench SHALL require err pulsed once and counting to continue uninterrupted.
REQ-035 rst asserted on the 3rd increment of RUN L=10: the bench SHALL require count=0, IDLE, and done never asserted.
